// File: rtl/xsim_dma_read_arbiter.sv
// Round-robin arbiter that shares one DMA read port among NREQ requesters.
// Only one transaction is outstanding at a time: grant -> wait for the response -> deliver it to the owner.
module xsim_dma_read_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_handle,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    input  logic                 dma_rdy_readrequest,
    output logic                 dma_en_readrequest,
    output logic [31:0]          dma_readrequest_addr,
    output logic [31:0]          dma_readrequest_handle,
    input  logic                 dma_rdy_readresponse,
    output logic                 dma_en_readresponse,
    input  logic [31:0]          dma_readresponse_data,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [31:0]          done_count
);

    localparam int W1 = IDW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_RSP, DELIVER} state_t;

    state_t          state_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic [IDW-1:0]  owner_reg;
    logic [IDW-1:0]  grant_id_reg;
    logic [31:0]     rsp_data_reg;
    logic [31:0]     done_count_reg;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [W1-1:0]   best_off;
    logic [W1-1:0]   off;
    logic [NREQ-1:0] owner_sel;
    logic            owner_rdy;
    logic            in_idle;
    logic            drain;
    logic            issue;
    logic            capture;
    logic            deliver;
    logic            complete;

    // Each requester's distance from rr_ptr (mod NREQ); the nearest valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        best_off    = '0;
        off         = '0;
        for (int i = 0; i < NREQ; i++) begin
            off = W1'(i) + W1'(NREQ) - {1'b0, rr_ptr_reg};
            if (off >= W1'(NREQ)) begin
                off = off - W1'(NREQ);
            end
            if (req_valid[i] && (!grant_found || off < best_off)) begin
                grant_found = 1'b1;
                best_off    = off;
                grant_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        dma_readrequest_addr   = '0;
        dma_readrequest_handle = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                dma_readrequest_addr   = req_addr[32*i +: 32];
                dma_readrequest_handle = req_handle[32*i +: 32];
            end
        end
    end

    // Every handshake is qualified by RST_N so nothing leaks out while reset is held.
    assign in_idle   = RST_N && (state_reg == IDLE);
    assign drain     = in_idle && dma_rdy_readresponse;
    assign issue     = in_idle && !dma_rdy_readresponse && dma_rdy_readrequest && grant_found;
    assign capture   = RST_N && (state_reg == WAIT_RSP) && dma_rdy_readresponse;
    assign deliver   = RST_N && (state_reg == DELIVER);
    assign owner_rdy = |(rsp_ready & owner_sel);
    assign complete  = deliver && owner_rdy;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign owner_sel[gi] = (owner_reg == IDW'(gi));
            assign req_ready[gi] = issue && (grant_idx == IDW'(gi));
            assign rsp_valid[gi] = deliver && owner_sel[gi];
        end
    endgenerate

    assign dma_en_readrequest  = issue;
    assign dma_en_readresponse = drain || capture;
    assign busy                = RST_N && (state_reg != IDLE);
    assign rsp_data            = rsp_data_reg;
    assign grant_id            = grant_id_reg;
    assign done_count          = done_count_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            owner_reg      <= '0;
            grant_id_reg   <= '0;
            rsp_data_reg   <= 32'hAAAAAAAA;
            done_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        owner_reg    <= grant_idx;
                        grant_id_reg <= grant_idx;
                        state_reg    <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (capture) begin
                        rsp_data_reg <= dma_readresponse_data;
                        state_reg    <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (complete) begin
                        state_reg      <= IDLE;
                        rr_ptr_reg     <= (owner_reg == IDW'(NREQ - 1)) ? '0 : owner_reg + IDW'(1);
                        done_count_reg <= done_count_reg + 32'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xsim_dma_read_arbiter.sv
// Scenario tasks plus a randomized run checked against a transaction-level round-robin model.
module tb_xsim_dma_read_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0]  req_handle;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_data;
    logic [NREQ-1:0]     rsp_ready;
    logic                dma_rdy_readrequest;
    logic                dma_en_readrequest;
    logic [31:0]         dma_readrequest_addr;
    logic [31:0]         dma_readrequest_handle;
    logic                dma_rdy_readresponse;
    logic                dma_en_readresponse;
    logic [31:0]         dma_readresponse_data;
    logic                busy;
    logic [IDW-1:0]      grant_id;
    logic [31:0]         done_count;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;
    int m_done = 0;
    logic [31:0] addr_m   [NREQ];
    logic [31:0] handle_m [NREQ];

    xsim_dma_read_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK                    (CLK),
        .RST_N                  (RST_N),
        .req_valid              (req_valid),
        .req_addr               (req_addr),
        .req_handle             (req_handle),
        .req_ready              (req_ready),
        .rsp_valid              (rsp_valid),
        .rsp_data               (rsp_data),
        .rsp_ready              (rsp_ready),
        .dma_rdy_readrequest    (dma_rdy_readrequest),
        .dma_en_readrequest     (dma_en_readrequest),
        .dma_readrequest_addr   (dma_readrequest_addr),
        .dma_readrequest_handle (dma_readrequest_handle),
        .dma_rdy_readresponse   (dma_rdy_readresponse),
        .dma_en_readresponse    (dma_en_readresponse),
        .dma_readresponse_data  (dma_readresponse_data),
        .busy                   (busy),
        .grant_id               (grant_id),
        .done_count             (done_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arbitration: first valid requester at or after ptr, wrapping modulo NREQ.
    function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic load_slots();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[32*i +: 32]   = addr_m[i];
            req_handle[32*i +: 32] = handle_m[i];
        end
    endtask

    task automatic quiet_inputs();
        req_valid            = '0;
        rsp_ready            = '0;
        dma_rdy_readrequest  = 1'b0;
        dma_rdy_readresponse = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        dma_rdy_readrequest = 1'b1;
        dma_rdy_readresponse = 1'b1;
        tick();
        tick();
        settle();
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid: got %h expected 0", rsp_valid); end
        checks++; if ({dma_en_readrequest, dma_en_readresponse, busy} !== 3'b000) begin errors++; $display("FAIL reset_en_busy: got %b expected 000", {dma_en_readrequest, dma_en_readresponse, busy}); end
        checks++; if (rsp_data !== 32'hAAAAAAAA) begin errors++; $display("FAIL reset_rsp_data: got %h expected aaaaaaaa", rsp_data); end
        checks++; if (done_count !== 32'd0 || grant_id !== 3'd0) begin errors++; $display("FAIL reset_counters: got done=%0d grant=%0d expected 0/0", done_count, grant_id); end
        quiet_inputs();
        tick();
        RST_N = 1'b1;
        m_ptr = 0;
        m_done = 0;
        $display("txn reset: state cleared");
    endtask

    task automatic test_single();
        addr_m[0] = 32'h100;
        handle_m[0] = 32'd5;
        load_slots();
        tick();
        req_valid = 4'b0001;
        dma_rdy_readrequest = 1'b1;
        settle();
        checks++; if (req_ready !== 4'b0001 || dma_en_readrequest !== 1'b1) begin errors++; $display("FAIL single_grant: got ready=%b en=%b expected 0001/1", req_ready, dma_en_readrequest); end
        checks++; if (dma_readrequest_addr !== 32'h100 || dma_readrequest_handle !== 32'd5) begin errors++; $display("FAIL single_addr: got %h/%h expected 100/5", dma_readrequest_addr, dma_readrequest_handle); end
        tick();
        quiet_inputs();
        dma_rdy_readresponse = 1'b1;
        dma_readresponse_data = 32'h12345678;
        settle();
        checks++; if (dma_en_readresponse !== 1'b1 || busy !== 1'b1 || rsp_valid !== 4'h0) begin errors++; $display("FAIL single_capture: got en=%b busy=%b rv=%b expected 1/1/0000", dma_en_readresponse, busy, rsp_valid); end
        tick();
        dma_rdy_readresponse = 1'b0;
        rsp_ready = 4'b0001;
        settle();
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'h12345678) begin errors++; $display("FAIL single_deliver: got rv=%b data=%h expected 0001/12345678", rsp_valid, rsp_data); end
        tick();
        rsp_ready = 4'b0000;
        settle();
        m_done = m_done + 1;
        m_ptr = 1;
        checks++; if (done_count !== 32'(m_done) || busy !== 1'b0) begin errors++; $display("FAIL single_done: got done=%0d busy=%b expected %0d/0", done_count, busy, m_done); end
        $display("txn single: grant=0 data=%h done=%0d", rsp_data, done_count);
    endtask

    task automatic test_fairness();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        logic [31:0] d;
        RST_N = 1'b0;
        quiet_inputs();
        tick();
        tick();
        RST_N = 1'b1;
        m_ptr = 0;
        m_done = 0;
        for (int n = 0; n < 6; n++) begin
            d = $urandom;
            req_valid = 4'hF;
            rsp_ready = 4'hF;
            dma_rdy_readrequest = 1'b1;
            settle();
            checks++; if (req_ready !== 4'(1 << order[n])) begin errors++; $display("FAIL fair_grant%0d: got %b expected %b", n, req_ready, 4'(1 << order[n])); end
            checks++; if (dma_readrequest_addr !== addr_m[order[n]]) begin errors++; $display("FAIL fair_addr%0d: got %h expected %h", n, dma_readrequest_addr, addr_m[order[n]]); end
            tick();
            dma_rdy_readresponse = 1'b1;
            dma_readresponse_data = d;
            settle();
            checks++; if (dma_en_readrequest !== 1'b0 || dma_en_readresponse !== 1'b1) begin errors++; $display("FAIL fair_wait%0d: got req_en=%b rsp_en=%b expected 0/1", n, dma_en_readrequest, dma_en_readresponse); end
            tick();
            dma_rdy_readresponse = 1'b0;
            settle();
            checks++; if (rsp_valid !== 4'(1 << order[n]) || rsp_data !== d || req_ready !== 4'h0) begin errors++; $display("FAIL fair_deliver%0d: got rv=%b data=%h rr=%b expected %b/%h/0000", n, rsp_valid, rsp_data, req_ready, 4'(1 << order[n]), d); end
            tick();
            m_done++;
            m_ptr = (order[n] + 1) % NREQ;
            $display("txn fair %0d: grant=%0d data=%h", n, order[n], d);
        end
        quiet_inputs();
        settle();
        checks++; if (done_count !== 32'd6) begin errors++; $display("FAIL fair_done: got %0d expected 6", done_count); end
    endtask

    task automatic test_skip();
        // Pointer sits at 2 after the fairness run; only requester 0 asks.
        req_valid = 4'b0001;
        dma_rdy_readrequest = 1'b1;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_grant: got %b expected 0001 (ptr %0d)", req_ready, m_ptr); end
        tick();
        quiet_inputs();
        dma_rdy_readresponse = 1'b1;
        dma_readresponse_data = 32'hC0DE0000;
        tick();
        dma_rdy_readresponse = 1'b0;
        rsp_ready = 4'b0001;
        tick();
        m_done++;
        m_ptr = 1;
        quiet_inputs();
        req_valid = 4'b0011;
        dma_rdy_readrequest = 1'b1;
        settle();
        checks++; if (req_ready !== 4'(1 << exp_grant(4'b0011, m_ptr))) begin errors++; $display("FAIL skip_ptr: got %b expected %b", req_ready, 4'(1 << exp_grant(4'b0011, m_ptr))); end
        dma_rdy_readrequest = 1'b0;
        req_valid = 4'b0000;
        settle();
        $display("txn skip: grant=0 new_ptr=%0d", m_ptr);
    endtask

    task automatic test_backpressure();
        int g;
        logic [31:0] d;
        d = $urandom;
        for (int c = 0; c < 5; c++) begin
            tick();
            req_valid = 4'b0100;
            dma_rdy_readrequest = 1'b0;
            settle();
            checks++; if (req_ready !== 4'h0 || dma_en_readrequest !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got ready=%b en=%b expected 0000/0", c, req_ready, dma_en_readrequest); end
        end
        tick();
        dma_rdy_readrequest = 1'b1;
        g = exp_grant(4'b0100, m_ptr);
        settle();
        checks++; if (req_ready !== 4'(1 << g) || dma_readrequest_handle !== handle_m[g]) begin errors++; $display("FAIL bp_grant: got %b/%h expected %b/%h", req_ready, dma_readrequest_handle, 4'(1 << g), handle_m[g]); end
        tick();
        quiet_inputs();
        dma_rdy_readresponse = 1'b1;
        dma_readresponse_data = d;
        tick();
        dma_rdy_readresponse = 1'b0;
        dma_readresponse_data = ~d;
        for (int c = 0; c < 4; c++) begin
            rsp_ready = 4'b1011;
            settle();
            checks++; if (rsp_valid !== 4'b0100 || rsp_data !== d) begin errors++; $display("FAIL bp_hold%0d: got rv=%b data=%h expected 0100/%h", c, rsp_valid, rsp_data, d); end
            tick();
        end
        rsp_ready = 4'b0100;
        tick();
        quiet_inputs();
        m_done++;
        m_ptr = (g + 1) % NREQ;
        settle();
        checks++; if (done_count !== 32'(m_done) || busy !== 1'b0) begin errors++; $display("FAIL bp_done: got %0d busy=%b expected %0d/0", done_count, busy, m_done); end
        $display("txn backpressure: grant=%0d data=%h done=%0d", g, d, done_count);
    endtask

    task automatic test_reset_midflight();
        tick();
        req_valid = 4'b1000;
        dma_rdy_readrequest = 1'b1;
        tick();
        quiet_inputs();
        req_valid = 4'b1111;
        dma_rdy_readrequest = 1'b1;
        dma_rdy_readresponse = 1'b1;
        RST_N = 1'b0;
        settle();
        checks++; if ({req_ready, rsp_valid} !== 8'h00 || {dma_en_readrequest, dma_en_readresponse, busy} !== 3'b000) begin errors++; $display("FAIL midrst_outputs: got rr=%b rv=%b en=%b%b busy=%b expected zeros", req_ready, rsp_valid, dma_en_readrequest, dma_en_readresponse, busy); end
        tick();
        tick();
        RST_N = 1'b1;
        req_valid = 4'b0010;
        settle();
        checks++; if (dma_en_readresponse !== 1'b1 || req_ready !== 4'h0 || dma_en_readrequest !== 1'b0 || rsp_valid !== 4'h0) begin errors++; $display("FAIL midrst_drain: got rsp_en=%b rr=%b req_en=%b rv=%b expected 1/0000/0/0000", dma_en_readresponse, req_ready, dma_en_readrequest, rsp_valid); end
        tick();
        dma_rdy_readresponse = 1'b0;
        m_ptr = 0;
        m_done = 0;
        settle();
        checks++; if (req_ready !== 4'(1 << exp_grant(4'b0010, m_ptr))) begin errors++; $display("FAIL midrst_grant: got %b expected 0010", req_ready); end
        tick();
        quiet_inputs();
        dma_rdy_readresponse = 1'b1;
        dma_readresponse_data = 32'h0BADF00D;
        tick();
        dma_rdy_readresponse = 1'b0;
        rsp_ready = 4'b0010;
        tick();
        quiet_inputs();
        m_done = 1;
        m_ptr = 2;
        $display("txn reset_midflight: drained then grant=1");
    endtask

    task automatic test_wrap();
        force dut.done_count_reg = 32'hFFFFFFFF;
        tick();
        release dut.done_count_reg;
        settle();
        checks++; if (done_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preset: got %h expected ffffffff", done_count); end
        tick();
        req_valid = 4'b0100;
        dma_rdy_readrequest = 1'b1;
        tick();
        quiet_inputs();
        dma_rdy_readresponse = 1'b1;
        dma_readresponse_data = 32'h5A5A5A5A;
        tick();
        dma_rdy_readresponse = 1'b0;
        rsp_ready = 4'b0100;
        tick();
        quiet_inputs();
        settle();
        m_done = 0;
        m_ptr = 3;
        checks++; if (done_count !== 32'd0) begin errors++; $display("FAIL wrap_done: got %h expected 0", done_count); end
        $display("txn wrap: done=%0d", done_count);
    endtask

    task automatic test_random();
        int g;
        logic [NREQ-1:0] v;
        logic r;
        logic drn;
        logic [31:0] d;
        for (int n = 0; n < 60; n++) begin
            if (n % 8 == 0) begin
                for (int i = 0; i < NREQ; i++) begin addr_m[i] = $urandom; handle_m[i] = $urandom; end
                load_slots();
            end
            g = -1;
            for (int c = 0; c < 20 && g < 0; c++) begin
                tick();
                v = 4'($urandom_range(0, 15));
                r = 1'($urandom_range(0, 1));
                drn = ($urandom_range(0, 9) == 0);
                if (c == 19) begin v = 4'($urandom_range(1, 15)); r = 1'b1; drn = 1'b0; end
                req_valid = v;
                dma_rdy_readrequest = r;
                dma_rdy_readresponse = drn;
                rsp_ready = 4'($urandom_range(0, 15));
                settle();
                if (drn) begin
                    checks++; if (dma_en_readresponse !== 1'b1 || req_ready !== 4'h0) begin errors++; $display("FAIL rnd_drain%0d: got rsp_en=%b rr=%b expected 1/0000", n, dma_en_readresponse, req_ready); end
                end else if (r && v != 0) begin
                    g = exp_grant(v, m_ptr);
                    checks++; if (req_ready !== 4'(1 << g) || dma_readrequest_addr !== addr_m[g] || dma_readrequest_handle !== handle_m[g]) begin errors++; $display("FAIL rnd_grant%0d: got rr=%b addr=%h expected %b/%h", n, req_ready, dma_readrequest_addr, 4'(1 << g), addr_m[g]); end
                end else begin
                    checks++; if (req_ready !== 4'h0 || dma_en_readrequest !== 1'b0) begin errors++; $display("FAIL rnd_idle%0d: got rr=%b en=%b expected 0000/0", n, req_ready, dma_en_readrequest); end
                end
            end
            for (int c = $urandom_range(0, 3); c > 0; c--) begin
                tick();
                req_valid = 4'($urandom_range(0, 15));
                dma_rdy_readrequest = 1'($urandom_range(0, 1));
                dma_rdy_readresponse = 1'b0;
                settle();
                checks++; if (dma_en_readrequest !== 1'b0 || dma_en_readresponse !== 1'b0 || rsp_valid !== 4'h0) begin errors++; $display("FAIL rnd_wait%0d: got req_en=%b rsp_en=%b rv=%b expected 0/0/0000", n, dma_en_readrequest, dma_en_readresponse, rsp_valid); end
            end
            tick();
            d = $urandom;
            dma_rdy_readresponse = 1'b1;
            dma_readresponse_data = d;
            settle();
            checks++; if (dma_en_readresponse !== 1'b1) begin errors++; $display("FAIL rnd_capture%0d: got %b expected 1", n, dma_en_readresponse); end
            for (int c = 0; c < 10; c++) begin
                tick();
                rsp_ready = 4'($urandom_range(0, 15));
                if (c == 9) rsp_ready[g] = 1'b1;
                dma_rdy_readresponse = 1'($urandom_range(0, 1));
                dma_readresponse_data = $urandom;
                req_valid = 4'($urandom_range(0, 15));
                dma_rdy_readrequest = 1'($urandom_range(0, 1));
                settle();
                checks++; if (rsp_valid !== 4'(1 << g) || rsp_data !== d || dma_en_readrequest !== 1'b0 || dma_en_readresponse !== 1'b0) begin errors++; $display("FAIL rnd_deliver%0d: got rv=%b data=%h en=%b%b expected %b/%h/00", n, rsp_valid, rsp_data, dma_en_readrequest, dma_en_readresponse, 4'(1 << g), d); end
                if (rsp_ready[g]) break;
            end
            tick();
            quiet_inputs();
            m_done++;
            m_ptr = (g + 1) % NREQ;
            settle();
            checks++; if (done_count !== 32'(m_done)) begin errors++; $display("FAIL rnd_done%0d: got %0d expected %0d", n, done_count, m_done); end
            $display("txn rnd %0d: grant=%0d data=%h done=%0d", n, g, d, done_count);
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin addr_m[i] = $urandom; handle_m[i] = $urandom; end
        load_slots();
        dma_readresponse_data = '0;
        quiet_inputs();
        RST_N = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_skip();
        test_backpressure();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xsim_dma_read_arbiter.md
XSIM_DMA_READ_ARBITER -- requirements
Module: xsim_dma_read_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of read requesters sharing one DMA read port; legal range 2..8.
REQ-002 Parameter IDW, default 3, width of grant_id; SHALL satisfy 2**IDW >= NREQ.
REQ-003 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 RST_N  in  1  reset, synchronous and active-low.
REQ-005 req_valid  in  NREQ  bit i: requester i holds a read request.
REQ-006 req_addr  in  32*NREQ  bits [32i+31:32i]: address of requester i.
REQ-007 req_handle  in  32*NREQ  bits [32i+31:32i]: memory handle of requester i.
REQ-008 req_ready  out  NREQ  bit i: request i accepted this cycle; at most one bit set.
REQ-009 rsp_valid  out  NREQ  bit i: rsp_data holds the response for requester i; at most one bit set.
REQ-010 rsp_data  out  32  registered read data.
REQ-011 rsp_ready  in  NREQ  bit i: requester i consumes its response this cycle.
REQ-012 dma_rdy_readrequest  in  1  DMA port can take a request.
REQ-013 dma_en_readrequest  out  1  request issued to DMA port this cycle.
REQ-014 dma_readrequest_addr / dma_readrequest_handle  out  32 each  muxed from granted requester.
REQ-015 dma_rdy_readresponse  in  1  DMA port holds valid read data.
REQ-016 dma_en_readresponse  out  1  DMA response consumed this cycle.
REQ-017 dma_readresponse_data  in  32  DMA read data.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 grant_id  out  IDW  index of current/last owner.
REQ-020 done_count  out  32  completed transactions, wraps 0xFFFFFFFF -> 0.

Function
REQ-021 FSM states SHALL be IDLE, WAIT_RSP, DELIVER; one transaction outstanding at most.
REQ-022 IDLE: if dma_rdy_readresponse=1, assert dma_en_readresponse, discard data, issue no request, stay IDLE (stale-response drain).
REQ-023 IDLE: else if any req_valid and dma_rdy_readrequest=1, grant first set req_valid at or after rr_ptr, scanning upward modulo NREQ.
REQ-024 Grant cycle: req_ready[g]=1, dma_en_readrequest=1, addr/handle from slice g, all combinational same cycle; owner<=g, grant_id<=g, next state WAIT_RSP.
REQ-025 IDLE with dma_rdy_readrequest=0: no req_ready, no dma_en_readrequest, stay IDLE.
REQ-026 WAIT_RSP: on dma_rdy_readresponse=1 assert dma_en_readresponse, rsp_data<=dma_readresponse_data, next DELIVER; else hold.
REQ-027 DELIVER: rsp_valid[owner]=1, others 0; rsp_data stable; on rsp_ready[owner]=1 -> IDLE, rr_ptr<=(owner+1) mod NREQ, done_count+=1.
REQ-028 rsp_ready bits of non-owners SHALL be ignored in all states.
REQ-029 No new request is issued in the cycle DELIVER completes; minimum 3 cycles per transaction (grant T, capture T+1, rsp_valid from T+2).
REQ-030 dma_en_readrequest and dma_en_readresponse SHALL never be asserted while the corresponding dma_rdy input is 0.
REQ-031 req_valid dropped by a non-granted requester SHALL have no effect; arbitration re-evaluated every IDLE cycle.

Reset
REQ-032 RST_N=0 at posedge: state<=IDLE, rr_ptr<=0, owner<=0, grant_id<=0, rsp_data<=32'hAAAAAAAA, done_count<=0.
REQ-033 While RST_N=0: req_ready, rsp_valid, dma_en_readrequest, dma_en_readresponse SHALL be 0; busy=0.
REQ-034 Reset mid-transaction drops the in-flight transaction; any DMA response still pending is drained per REQ-022 after reset release.

Verification
REQ-035 Single: req_valid=0001, addr 0x100, handle 5, DMA returns 0x12345678 one cycle later -> req_ready=0001 at T, dma_en_readresponse at T+1, rsp_valid=0001 rsp_data=0x12345678 at T+2, done_count=1.
REQ-036 Fairness: req_valid=1111 held, rsp_ready=1111 -> grant order 0,1,2,3,0,1; done_count=6 after six transactions.
REQ-037 Backpressure: dma_rdy_readrequest=0 for 5 cycles with req_valid=0100 -> no req_ready; grant on first cycle it rises; rsp_ready held 0 for 4 cycles in DELIVER -> rsp_valid and rsp_data stable.
REQ-038 Skip: rr_ptr=2, req_valid=0001 -> grant 0, rr_ptr becomes 1.
REQ-039 Reset in WAIT_RSP with DMA response pending -> outputs 0 during reset; first IDLE cycle after release drains (dma_en_readresponse=1, no rsp_valid), next cycle grants normally.
REQ-040 Wrap: force done_count to 0xFFFFFFFF, complete one transaction -> done_count=0.
